// File: rtl/cellrv32_npu_pkg.sv
// Shared types for the NPU accumulator address generator.
//   npu_acc_ag_state_t : generator FSM states (IDLE, RUN, DONE)
//   NPU_AG_MODE_*      : pass mode encodings for cfg_mode_i
package cellrv32_npu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } npu_acc_ag_state_t;

  localparam logic NPU_AG_MODE_RESTART = 1'b0;
  localparam logic NPU_AG_MODE_LINEAR  = 1'b1;

endpackage

// File: rtl/cellrv32_npu_acc_addr_stride_adder.sv
// Registered address adder: sum_o = a_i + b_i, one cycle later.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (sum clears to 0)
//   a_i, b_i     : operands (modulo 2^ADDR_WIDTH)
//   sum_o        : registered sum
module cellrv32_npu_acc_addr_stride_adder #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] a_i,
  input  logic [ADDR_WIDTH-1:0] b_i,
  output logic [ADDR_WIDTH-1:0] sum_o
);

  (* use_dsp = "yes" *) logic [ADDR_WIDTH-1:0] sum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= a_i + b_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/cellrv32_npu_acc_addr_gen.sv
// Accumulator address generator for the NPU matrix unit.
// Generates len addresses per pass (base, base+stride, ...), for repeat
// passes (0 = endless), restarting at base (mode 0) or continuing linearly
// (mode 1). Optional output register stage: CELLRV32_NPU_ACC_ADDR_OUT_REG_EN.
// Ports:
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   cfg_valid_i / cfg_ready_o : config handshake (ready while IDLE)
//   cfg_base_i, cfg_len_i, cfg_stride_i, cfg_repeat_i, cfg_mode_i : run config
//   step_i                    : consumer takes the current address
//   abort_i                   : terminate a run without done_o
//   addr_valid_o, addr_o      : current address
//   last_o                    : current address ends its pass
//   done_o                    : one-cycle completion pulse
//   busy_o                    : not IDLE
module cellrv32_npu_acc_addr_gen
  import cellrv32_npu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned REP_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [LEN_WIDTH-1:0]  cfg_len_i,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
  input  logic [REP_WIDTH-1:0]  cfg_repeat_i,
  input  logic                  cfg_mode_i,
  input  logic                  step_i,
  input  logic                  abort_i,
  output logic                  addr_valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  done_o,
  output logic                  busy_o
);

  npu_acc_ag_state_t     state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, stride_q, stride_d, cur_q, cur_d, sum;
  logic [LEN_WIDTH-1:0]  len_q, idx_q, idx_d;
  logic [REP_WIDTH-1:0]  rep_q, pass_q, pass_d, pass_inc;
  logic                  mode_q;
  logic                  accept, int_valid, int_last, step_int, final_step;

`ifdef CELLRV32_NPU_ACC_ADDR_OUT_REG_EN
  logic                  fin_q, fin_d;
  logic                  out_v_q, out_last_q, done_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
`endif

  assign accept   = cfg_valid_i & (state_q == IDLE);
  assign int_last = (idx_q == (len_q - LEN_WIDTH'(1)));
  assign pass_inc = pass_q + REP_WIDTH'(1);

`ifdef CELLRV32_NPU_ACC_ADDR_OUT_REG_EN
  // Internal generator runs ahead into the output stage; it stops once the
  // final address has been loaded and waits for that one to be consumed.
  assign int_valid = (state_q == RUN) & ~fin_q;
  assign step_int  = int_valid & ~abort_i & (~out_v_q | step_i);
`else
  assign int_valid = (state_q == RUN);
  assign step_int  = int_valid & ~abort_i & step_i;
`endif

  assign final_step = step_int & int_last & (rep_q != '0) & (pass_inc == rep_q);

  // The adder is fed the *next* cur/stride so that sum == cur_q + stride_q
  // holds every cycle despite the adder's register.
  cellrv32_npu_acc_addr_stride_adder #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_stride_adder (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .a_i   (cur_d),
    .b_i   (stride_d),
    .sum_o (sum)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
`ifdef CELLRV32_NPU_ACC_ADDR_OUT_REG_EN
    fin_d    = fin_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_d    = cfg_base_i;
          stride_d = cfg_stride_i;
          idx_d    = '0;
          pass_d   = '0;
`ifdef CELLRV32_NPU_ACC_ADDR_OUT_REG_EN
          fin_d    = 1'b0;
`endif
          state_d  = (cfg_len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          if (step_int) begin
            if (int_last) begin
              idx_d  = '0;
              pass_d = pass_inc;
              cur_d  = (mode_q == NPU_AG_MODE_LINEAR) ? sum : base_q;
              if (final_step) begin
`ifdef CELLRV32_NPU_ACC_ADDR_OUT_REG_EN
                fin_d = 1'b1;
`else
                state_d = DONE;
`endif
              end
            end else begin
              idx_d = idx_q + LEN_WIDTH'(1);
              cur_d = sum;
            end
          end
`ifdef CELLRV32_NPU_ACC_ADDR_OUT_REG_EN
          if (fin_q & out_v_q & step_i) begin
            state_d = DONE;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      base_q   <= '0;
      stride_q <= '0;
      cur_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      rep_q    <= '0;
      pass_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      if (accept) begin
        base_q <= cfg_base_i;
        len_q  <= cfg_len_i;
        rep_q  <= cfg_repeat_i;
        mode_q <= cfg_mode_i;
      end
    end
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

`ifdef CELLRV32_NPU_ACC_ADDR_OUT_REG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fin_q      <= 1'b0;
      out_v_q    <= 1'b0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fin_q  <= fin_d;
      done_q <= (state_q == DONE);
      if ((state_q == RUN) && abort_i) begin
        out_v_q    <= 1'b0;
        out_last_q <= 1'b0;
      end else if (step_int) begin
        out_v_q    <= 1'b1;
        out_addr_q <= cur_q;
        out_last_q <= int_last;
      end else if (out_v_q && step_i) begin
        out_v_q    <= 1'b0;
        out_last_q <= 1'b0;
      end
    end
  end

  assign addr_valid_o = out_v_q;
  assign addr_o       = out_addr_q;
  assign last_o       = out_v_q & out_last_q;
  assign done_o       = done_q;
`else
  assign addr_valid_o = (state_q == RUN);
  assign addr_o       = cur_q;
  assign last_o       = (state_q == RUN) & int_last;
  assign done_o       = (state_q == DONE);
`endif

endmodule

// File: tb/tb_cellrv32_npu_acc_addr_gen.sv
module tb_cellrv32_npu_acc_addr_gen;

  typedef struct {
    logic [31:0] base;
    logic [7:0]  len;
    logic [31:0] stride;
    logic [7:0]  rep;
    logic        mode;
    bit          rnd;
  } vec_t;

  typedef struct {
    int unsigned row;
    logic [31:0] addr;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        last;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [31:0] cfg_base_i;
  logic [7:0]  cfg_len_i;
  logic [31:0] cfg_stride_i;
  logic [7:0]  cfg_repeat_i;
  logic        cfg_mode_i;
  logic        step_i;
  logic        abort_i;
  logic        addr_valid_o;
  logic [31:0] addr_o;
  logic        last_o;
  logic        done_o;
  logic        busy_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  vec_t vecs [6];
  exp_t exps [26];
  sb_t  sb_q [$];

  cellrv32_npu_acc_addr_gen #(
    .ADDR_WIDTH(32),
    .LEN_WIDTH (8),
    .REP_WIDTH (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_base_i   (cfg_base_i),
    .cfg_len_i    (cfg_len_i),
    .cfg_stride_i (cfg_stride_i),
    .cfg_repeat_i (cfg_repeat_i),
    .cfg_mode_i   (cfg_mode_i),
    .step_i       (step_i),
    .abort_i      (abort_i),
    .addr_valid_o (addr_valid_o),
    .addr_o       (addr_o),
    .last_o       (last_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, cfg_ready_o, 1);
    check({tag, "_valid"}, addr_valid_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (!cfg_ready_o && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", cfg_ready_o, 1);
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_valid_i  = 1'b1;
    cfg_base_i   = v.base;
    cfg_len_i    = v.len;
    cfg_stride_i = v.stride;
    cfg_repeat_i = v.rep;
    cfg_mode_i   = v.mode;
  endtask

  task automatic run_row(input int unsigned r);
    int unsigned since;
    bit          seen_done;
    sb_t         e;
    for (int unsigned i = 0; i < 26; i++) begin
      if (exps[i].row == r) begin
        e.addr = exps[i].addr;
        e.last = exps[i].last;
        sb_q.push_back(e);
      end
    end
    wait_ready();
    drive_cfg(vecs[r]);
    since = 0;
    tick();
    since++;
    cfg_valid_i = 1'b0;
    seen_done   = 1'b0;
    for (int unsigned cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      step_i = 1'b0;
      if (done_o) begin
        check("done_latency", since, 1);
        check("done_valid_low", addr_valid_o, 0);
        check("sb_drained", sb_q.size(), 0);
        seen_done = 1'b1;
      end else if (addr_valid_o) begin
        check("addr_unexpected", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          check("addr", addr_o, sb_q[0].addr);
          check("last", last_o, sb_q[0].last);
          step_i = vecs[r].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (step_i) begin
            void'(sb_q.pop_front());
            since = 0;
          end
        end
      end
      if (!seen_done) begin
        tick();
        since++;
      end
    end
    check("done_seen", seen_done, 1);
    step_i = 1'b0;
    sb_q.delete();
    tick();
    check_idle("post_done");
  endtask

  initial begin
    bit          ph;
    logic [31:0] ea;
    vec_t        v;

    vecs = '{
      '{32'h0000_0100, 8'd4, 32'd2,    8'd1, 1'b0, 1'b0},
      '{32'h0000_0010, 8'd3, 32'd1,    8'd2, 1'b0, 1'b0},
      '{32'h0000_0010, 8'd3, 32'd1,    8'd2, 1'b1, 1'b1},
      '{32'hFFFF_FFFE, 8'd4, 32'd1,    8'd1, 1'b0, 1'b0},
      '{32'h0000_0500, 8'd0, 32'd1,    8'd3, 1'b0, 1'b0},
      '{32'h0000_0200, 8'd2, 32'h10,   8'd3, 1'b1, 1'b1}
    };
    exps = '{
      '{0, 32'h100, 1'b0}, '{0, 32'h102, 1'b0}, '{0, 32'h104, 1'b0}, '{0, 32'h106, 1'b1},
      '{1, 32'h10, 1'b0}, '{1, 32'h11, 1'b0}, '{1, 32'h12, 1'b1},
      '{1, 32'h10, 1'b0}, '{1, 32'h11, 1'b0}, '{1, 32'h12, 1'b1},
      '{2, 32'h10, 1'b0}, '{2, 32'h11, 1'b0}, '{2, 32'h12, 1'b1},
      '{2, 32'h13, 1'b0}, '{2, 32'h14, 1'b0}, '{2, 32'h15, 1'b1},
      '{3, 32'hFFFF_FFFE, 1'b0}, '{3, 32'hFFFF_FFFF, 1'b0},
      '{3, 32'h0, 1'b0}, '{3, 32'h1, 1'b1},
      '{5, 32'h200, 1'b0}, '{5, 32'h210, 1'b1}, '{5, 32'h220, 1'b0},
      '{5, 32'h230, 1'b1}, '{5, 32'h240, 1'b0}, '{5, 32'h250, 1'b1}
    };

    rst_i        = 1'b1;
    cfg_valid_i  = 1'b0;
    cfg_base_i   = '0;
    cfg_len_i    = '0;
    cfg_stride_i = '0;
    cfg_repeat_i = '0;
    cfg_mode_i   = 1'b0;
    step_i       = 1'b0;
    abort_i      = 1'b0;

    #2;
    check_idle("reset");
    check("reset_addr", addr_o, 0);
    check("reset_last", last_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    tick();

    for (int unsigned r = 0; r < 6; r++) begin
      run_row(r);
    end

    // Endless run: addresses alternate, hold without step, abort beats step.
    wait_ready();
    v = '{32'h40, 8'd2, 32'd4, 8'd0, 1'b0, 1'b0};
    drive_cfg(v);
    tick();
    cfg_valid_i = 1'b0;
    ph = 1'b0;
    for (int unsigned c = 0; c < 50; c++) begin
      ea = ph ? 32'h44 : 32'h40;
      check("endless_valid", addr_valid_o, 1);
      check("endless_addr", addr_o, ea);
      check("endless_last", last_o, ph);
      check("endless_done", done_o, 0);
      step_i = 1'($urandom_range(0, 1));
      if (step_i) ph = ~ph;
      tick();
    end
    step_i  = 1'b1;
    abort_i = 1'b1;
    tick();
    step_i  = 1'b0;
    abort_i = 1'b0;
    check_idle("abort");
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check("abort_no_done", done_o, 0);
    end

    // cfg_valid_i held through RUN must not re-accept; then async reset mid-run.
    wait_ready();
    v = '{32'h300, 8'd8, 32'd1, 8'd1, 1'b0, 1'b0};
    drive_cfg(v);
    tick();
    cfg_base_i = 32'h999;
    for (int unsigned k = 0; k < 4; k++) begin
      check("hold_busy", busy_o, 1);
      check("hold_ready", cfg_ready_o, 0);
      check("hold_addr", addr_o, 32'h300 + k);
      step_i = (k < 3);
      tick();
    end
    step_i = 1'b0;
    #3;
    rst_i = 1'b1;
    #1;
    check_idle("midrst");
    check("midrst_addr", addr_o, 0);
    check("midrst_last", last_o, 0);
    cfg_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check_idle("after_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
